// File: rtl/fetdriver_seq_pkg.sv
// Shared types and fault codes for the FET driver sequencer.
package fetdriver_seq_pkg;

    typedef enum logic [2:0] {
        StOff   = 3'd0,
        StDead  = 3'd1,
        StHsOn  = 3'd2,
        StLsOn  = 3'd3,
        StFault = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SideNone = 2'd0,
        SideHs   = 2'd1,
        SideLs   = 2'd2
    } side_e;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_OFF_TMO = 2'd1;
    localparam logic [1:0] FC_ON_TMO  = 2'd2;
    localparam logic [1:0] FC_SHOOT   = 2'd3;

endpackage

// File: rtl/fetdriver_status_sync.sv
// Flop-chain synchronizer for one asynchronous gate_status return.
module fetdriver_status_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetb,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/fetdriver_sequencer.sv
// High/low-side FET driver sequencer: status-confirmed dead time, timeout and
// shoot-through detection, sticky fault with gates held off.
module fetdriver_sequencer
    import fetdriver_seq_pkg::*;
#(
    parameter int unsigned DEADTIME    = 4,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       enable,
    input  logic       pwm_in,
    input  logic       fault_clr,
    input  logic       hs_gate_status,
    input  logic       ls_gate_status,
    output logic       hs_fetin,
    output logic       ls_fetin,
    output logic       enable_fetdriver,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state_dbg
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t DeadMax = cnt_t'(DEADTIME);
    localparam cnt_t TmoMax  = cnt_t'(TIMEOUT);

    logic hs_st, ls_st;

    fetdriver_status_sync #(.SYNC_STAGES(SYNC_STAGES)) u_hs_sync (
        .clk      (clk),
        .resetb   (resetb),
        .async_in (hs_gate_status),
        .sync_out (hs_st)
    );

    fetdriver_status_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ls_sync (
        .clk      (clk),
        .resetb   (resetb),
        .async_in (ls_gate_status),
        .sync_out (ls_st)
    );

    state_e     state_q, state_d;
    side_e      side_q, side_d;
    cnt_t       dead_q, dead_d, tmo_q, tmo_d;
    cnt_t       dead_inc, tmo_inc;
    logic [1:0] code_q, code_d;
    logic       hs_fetin_q, hs_fetin_d, ls_fetin_q, ls_fetin_d;
    logic       en_q, en_d, fault_q, fault_d;
    logic       off_side_clear;

    assign dead_inc = (dead_q == DeadMax) ? dead_q : dead_q + cnt_t'(1);
    assign tmo_inc  = (tmo_q == TmoMax) ? tmo_q : tmo_q + cnt_t'(1);

    // The side that was just switched off must confirm low before dead time may end.
    always_comb begin
        off_side_clear = !hs_st && !ls_st;
        case (side_q)
            SideHs:  off_side_clear = !hs_st;
            SideLs:  off_side_clear = !ls_st;
            default: off_side_clear = !hs_st && !ls_st;
        endcase
    end

    always_comb begin
        state_d = state_q;
        side_d  = side_q;
        dead_d  = dead_q;
        tmo_d   = tmo_q;
        code_d  = code_q;

        case (state_q)
            StOff: begin
                if (enable) begin
                    state_d = StDead;
                    side_d  = SideNone;
                end
            end
            StDead: begin
                dead_d = dead_inc;
                tmo_d  = tmo_inc;
                if (dead_q == DeadMax && off_side_clear) begin
                    state_d = pwm_in ? StHsOn : StLsOn;
                    dead_d  = '0;
                    tmo_d   = '0;
                end else if (tmo_inc == TmoMax) begin
                    state_d = StFault;
                    code_d  = FC_OFF_TMO;
                end
            end
            StHsOn: begin
                if (!hs_st && tmo_inc == TmoMax) begin
                    state_d = StFault;
                    code_d  = FC_ON_TMO;
                end else begin
                    if (!hs_st) tmo_d = tmo_inc;
                    if (!pwm_in) begin
                        state_d = StDead;
                        side_d  = SideHs;
                        dead_d  = '0;
                        tmo_d   = '0;
                    end
                end
            end
            StLsOn: begin
                if (!ls_st && tmo_inc == TmoMax) begin
                    state_d = StFault;
                    code_d  = FC_ON_TMO;
                end else begin
                    if (!ls_st) tmo_d = tmo_inc;
                    if (pwm_in) begin
                        state_d = StDead;
                        side_d  = SideLs;
                        dead_d  = '0;
                        tmo_d   = '0;
                    end
                end
            end
            StFault: begin
                if (fault_clr && !hs_st && !ls_st) begin
                    state_d = StOff;
                    code_d  = FC_NONE;
                end
            end
            default: state_d = StOff;
        endcase

        // Shoot-through outranks every timeout; disable only applies when no fault fires.
        if (state_q inside {StDead, StHsOn, StLsOn}) begin
            if (hs_st && ls_st) begin
                state_d = StFault;
                code_d  = FC_SHOOT;
            end else if (!enable && state_d != StFault) begin
                state_d = StOff;
            end
        end

        if (state_d inside {StOff, StFault}) begin
            dead_d = '0;
            tmo_d  = '0;
        end

        hs_fetin_d = (state_d == StHsOn);
        ls_fetin_d = (state_d == StLsOn);
        en_d       = (state_d inside {StDead, StHsOn, StLsOn}) ||
                     (state_d == StFault && enable);
        fault_d    = (state_d == StFault);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= StOff;
            side_q     <= SideNone;
            dead_q     <= '0;
            tmo_q      <= '0;
            code_q     <= FC_NONE;
            hs_fetin_q <= 1'b0;
            ls_fetin_q <= 1'b0;
            en_q       <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            side_q     <= side_d;
            dead_q     <= dead_d;
            tmo_q      <= tmo_d;
            code_q     <= code_d;
            hs_fetin_q <= hs_fetin_d;
            ls_fetin_q <= ls_fetin_d;
            en_q       <= en_d;
            fault_q    <= fault_d;
        end
    end

    assign hs_fetin         = hs_fetin_q;
    assign ls_fetin         = ls_fetin_q;
    assign enable_fetdriver = en_q;
    assign fault            = fault_q;
    assign fault_code       = code_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_fetdriver_sequencer.sv
// Directed bench for fetdriver_sequencer with a 3-cycle-lag gate driver model.
module tb_fetdriver_sequencer;
    import fetdriver_seq_pkg::*;

    logic       clk = 1'b0;
    logic       resetb = 1'b1;
    logic       enable = 1'b0;
    logic       pwm_in = 1'b0;
    logic       fault_clr = 1'b0;
    logic       hs_gate_status, ls_gate_status;
    logic       hs_fetin, ls_fetin, enable_fetdriver, fault;
    logic [1:0] fault_code;
    logic [2:0] state_dbg;

    logic [2:0] hs_lag = '0;
    logic [2:0] ls_lag = '0;
    logic       force_hs_en = 1'b0, force_hs_val = 1'b0;
    logic       force_ls_en = 1'b0, force_ls_val = 1'b0;

    int tests = 0;
    int fails = 0;
    int n;

    localparam int SelHs    = 0;
    localparam int SelLs    = 1;
    localparam int SelFault = 2;

    fetdriver_sequencer #(.DEADTIME(4), .TIMEOUT(16), .SYNC_STAGES(2)) dut (
        .clk              (clk),
        .resetb           (resetb),
        .enable           (enable),
        .pwm_in           (pwm_in),
        .fault_clr        (fault_clr),
        .hs_gate_status   (hs_gate_status),
        .ls_gate_status   (ls_gate_status),
        .hs_fetin         (hs_fetin),
        .ls_fetin         (ls_fetin),
        .enable_fetdriver (enable_fetdriver),
        .fault            (fault),
        .fault_code       (fault_code),
        .state_dbg        (state_dbg)
    );

    always #5 clk = ~clk;

    // Driver model: gate_status follows fetin three clocks later unless overridden.
    always @(posedge clk) begin
        hs_lag <= {hs_lag[1:0], hs_fetin};
        ls_lag <= {ls_lag[1:0], ls_fetin};
    end
    assign hs_gate_status = force_hs_en ? force_hs_val : hs_lag[2];
    assign ls_gate_status = force_ls_en ? force_ls_val : ls_lag[2];

    always @(negedge clk) begin
        if (resetb) begin
            tests++;
            assert (!(hs_fetin === 1'b1 && ls_fetin === 1'b1)) else begin
                fails++;
                $error("FAIL both_fetin_high: observed hs=%b ls=%b expected not both 1",
                       hs_fetin, ls_fetin);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            SelHs:   return hs_fetin;
            SelLs:   return ls_fetin;
            default: return fault;
        endcase
    endfunction

    // Negedges until the selected output reads val; -1 if the limit expires.
    task automatic wait_for(input int sel, input logic val, input int limit, output int cnt);
        cnt = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (pick(sel) === val) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
    endtask

    initial begin
        #2 resetb = 1'b0;
        step(3);
        check("rst_state", 32'(state_dbg), 32'(StOff));
        check("rst_hs", 32'(hs_fetin), 0);
        check("rst_ls", 32'(ls_fetin), 0);
        check("rst_en", 32'(enable_fetdriver), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_code", 32'(fault_code), 0);
        resetb = 1'b1;
        step(2);
        check("idle_off", 32'(state_dbg), 32'(StOff));

        // Start-up into the low side
        enable = 1'b1;
        pwm_in = 1'b0;
        step(1);
        check("start_dead", 32'(state_dbg), 32'(StDead));
        check("start_en", 32'(enable_fetdriver), 1);
        wait_for(SelLs, 1'b1, 20, n);
        check("ls_on_latency", 32'(n), 5);
        check("ls_on_state", 32'(state_dbg), 32'(StLsOn));
        step(8);
        check("ls_on_nofault", 32'(fault), 0);

        // Low -> high commutation; ls status takes 5 cycles to drop through lag + sync
        pwm_in = 1'b1;
        step(1);
        check("ls_off_next", 32'(ls_fetin), 0);
        check("commute_dead", 32'(state_dbg), 32'(StDead));
        wait_for(SelHs, 1'b1, 20, n);
        check("hs_on_latency", 32'(n), 6);
        step(10);
        check("hs_on_state", 32'(state_dbg), 32'(StHsOn));
        check("hs_on_nofault", 32'(fault), 0);

        // Stuck hs status in DEAD; ls status arrives the same cycle the timeout would hit
        pwm_in = 1'b0;
        force_hs_en = 1'b1;
        force_hs_val = 1'b1;
        step(14);
        check("prio_dead_wait", 32'(state_dbg), 32'(StDead));
        force_ls_en = 1'b1;
        force_ls_val = 1'b1;
        wait_for(SelFault, 1'b1, 10, n);
        check("prio_latency", 32'(n), 3);
        check("prio_code", 32'(fault_code), 32'(FC_SHOOT));
        enable = 1'b0;
        step(1);
        check("fault_dis_en", 32'(enable_fetdriver), 0);
        check("fault_dis_latched", 32'(fault), 1);
        force_hs_en = 1'b0;
        force_ls_en = 1'b0;
        step(3);
        pulse_clr();
        check("clr1_state", 32'(state_dbg), 32'(StOff));
        check("clr1_code", 32'(fault_code), 0);

        // Turn-off timeout: hs status stuck after hs_fetin drops
        enable = 1'b1;
        pwm_in = 1'b1;
        step(1);
        wait_for(SelHs, 1'b1, 20, n);
        check("hs_from_off", 32'(n), 5);
        step(8);
        pwm_in = 1'b0;
        force_hs_en = 1'b1;
        force_hs_val = 1'b1;
        step(1);
        check("offtmo_dead", 32'(state_dbg), 32'(StDead));
        wait_for(SelFault, 1'b1, 30, n);
        check("offtmo_latency", 32'(n), 16);
        check("offtmo_code", 32'(fault_code), 32'(FC_OFF_TMO));
        check("offtmo_hs", 32'(hs_fetin), 0);
        check("offtmo_ls", 32'(ls_fetin), 0);
        check("offtmo_en", 32'(enable_fetdriver), 1);
        pulse_clr();
        check("offtmo_clr_rej", 32'(state_dbg), 32'(StFault));
        force_hs_en = 1'b0;
        step(3);
        enable = 1'b0;
        pulse_clr();
        check("clr2_state", 32'(state_dbg), 32'(StOff));
        check("clr2_fault", 32'(fault), 0);

        // Turn-on timeout: ls status never confirms
        force_ls_en = 1'b1;
        force_ls_val = 1'b0;
        enable = 1'b1;
        pwm_in = 1'b0;
        step(1);
        wait_for(SelLs, 1'b1, 20, n);
        check("ontmo_ls_on", 32'(n), 5);
        wait_for(SelFault, 1'b1, 30, n);
        check("ontmo_latency", 32'(n), 16);
        check("ontmo_code", 32'(fault_code), 32'(FC_ON_TMO));
        force_hs_en = 1'b1;
        force_hs_val = 1'b1;
        step(3);
        pulse_clr();
        check("ontmo_clr_rej", 32'(state_dbg), 32'(StFault));
        check("ontmo_code_held", 32'(fault_code), 32'(FC_ON_TMO));
        force_hs_en = 1'b0;
        step(3);
        enable = 1'b0;
        pulse_clr();
        check("clr3_state", 32'(state_dbg), 32'(StOff));
        check("clr3_code", 32'(fault_code), 0);
        force_ls_en = 1'b0;

        // Shoot-through during HS_ON
        enable = 1'b1;
        pwm_in = 1'b1;
        step(1);
        wait_for(SelHs, 1'b1, 20, n);
        step(8);
        force_ls_en = 1'b1;
        force_ls_val = 1'b1;
        wait_for(SelFault, 1'b1, 10, n);
        check("shoot_latency", 32'(n), 3);
        check("shoot_code", 32'(fault_code), 32'(FC_SHOOT));
        check("shoot_hs_off", 32'(hs_fetin), 0);
        enable = 1'b0;
        force_ls_en = 1'b0;
        step(6);
        pulse_clr();
        check("clr4_state", 32'(state_dbg), 32'(StOff));

        // Asynchronous reset mid-DEAD
        enable = 1'b1;
        step(2);
        check("mid_dead", 32'(state_dbg), 32'(StDead));
        resetb = 1'b0;
        #1;
        check("async_rst_state", 32'(state_dbg), 32'(StOff));
        check("async_rst_en", 32'(enable_fetdriver), 0);
        step(1);
        resetb = 1'b1;
        step(1);
        check("post_rst_dead", 32'(state_dbg), 32'(StDead));
        wait_for(SelHs, 1'b1, 20, n);
        check("post_rst_hs_on", 32'(n), 5);

        // Disable mid-HS_ON
        step(3);
        enable = 1'b0;
        step(1);
        check("dis_state", 32'(state_dbg), 32'(StOff));
        check("dis_hs", 32'(hs_fetin), 0);
        check("dis_en", 32'(enable_fetdriver), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
